matrix_op_dispatcher: RTL and testbench

// - Command front-end for the matrix operation units (add, mul, scalar, transpose, ...).
// - Accepts one command (opcode + operand ids) and pulses start to the selected unit.
// - While that unit runs, routes the shared storage read port and result-writer handshake to it.
// - On completion, returns the unit's status and the run-cycle count.
// - Sits between the command decoder/UI and the NUM_UNITS op units; one op in flight at a time.

---
 rtl/matrix_op_defs_pkg.sv | 32 +++
 rtl/matrix_op_port_mux.sv | 65 ++++++
 rtl/matrix_op_dispatcher.sv | 177 +++++++++++++++++
 tb/tb_matrix_op_dispatcher.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_op_defs_pkg.sv
// Shared types and constants for the matrix operation units and their dispatcher.
package matrix_op_defs_pkg;

    localparam int MATRIX_ADDR_WIDTH = 12;
    localparam int MATRIX_DATA_WIDTH = 16;
    localparam int NUM_UNITS_MAX     = 8;
    localparam int OP_SEL_W          = $clog2(NUM_UNITS_MAX);
    localparam int STATUS_W          = 3;

    typedef enum logic [STATUS_W-1:0] {
        MATRIX_OP_STATUS_IDLE         = 3'd0,
        MATRIX_OP_STATUS_BUSY         = 3'd1,
        MATRIX_OP_STATUS_SUCCESS      = 3'd2,
        MATRIX_OP_STATUS_ERR_DIM      = 3'd3,
        MATRIX_OP_STATUS_ERR_CAPACITY = 3'd4,
        MATRIX_OP_STATUS_ERR_INTERNAL = 3'd5
    } matrix_op_status_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        REPORT    = 3'd4
    } state_t;

    localparam logic [OP_SEL_W-1:0] OP_ADD       = OP_SEL_W'(0);
    localparam logic [OP_SEL_W-1:0] OP_MUL       = OP_SEL_W'(1);
    localparam logic [OP_SEL_W-1:0] OP_SCALAR    = OP_SEL_W'(2);
    localparam logic [OP_SEL_W-1:0] OP_TRANSPOSE = OP_SEL_W'(3);

endpackage

// File: rtl/matrix_op_port_mux.sv
// One-hot select plus enable: funnels the selected unit's read address and writer
// fields out, and hands the writer's ready/done back to that unit only.
module matrix_op_port_mux #(
    parameter int N  = 4,
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic                 en,
    input  logic [N-1:0]         sel,
    input  logic [N-1:0][AW-1:0] unit_read_addr,
    output logic [AW-1:0]        mem_read_addr,
    input  logic [N-1:0]         unit_write_request,
    input  logic [N-1:0]         unit_data_valid,
    input  logic [N-1:0][2:0]    unit_matrix_id,
    input  logic [N-1:0][7:0]    unit_rows,
    input  logic [N-1:0][7:0]    unit_cols,
    input  logic [N-1:0][63:0]   unit_name,
    input  logic [N-1:0][DW-1:0] unit_data_in,
    output logic                 wr_write_request,
    output logic                 wr_data_valid,
    output logic [2:0]           wr_matrix_id,
    output logic [7:0]           wr_rows,
    output logic [7:0]           wr_cols,
    output logic [63:0]          wr_name,
    output logic [DW-1:0]        wr_data,
    input  logic                 wr_write_ready,
    input  logic                 wr_writer_ready,
    input  logic                 wr_write_done,
    output logic [N-1:0]         unit_write_ready,
    output logic [N-1:0]         unit_writer_ready,
    output logic [N-1:0]         unit_write_done
);

    logic [N-1:0] gate;
    assign gate = en ? sel : '0;

    // With a one-hot (or all-zero) gate, OR-ing the masked lanes is a plain mux.
    always_comb begin
        mem_read_addr    = '0;
        wr_write_request = 1'b0;
        wr_data_valid    = 1'b0;
        wr_matrix_id     = '0;
        wr_rows          = '0;
        wr_cols          = '0;
        wr_name          = '0;
        wr_data          = '0;
        for (int i = 0; i < N; i++) begin
            if (gate[i]) begin
                mem_read_addr    = mem_read_addr | unit_read_addr[i];
                wr_write_request = wr_write_request | unit_write_request[i];
                wr_data_valid    = wr_data_valid | unit_data_valid[i];
                wr_matrix_id     = wr_matrix_id | unit_matrix_id[i];
                wr_rows          = wr_rows | unit_rows[i];
                wr_cols          = wr_cols | unit_cols[i];
                wr_name          = wr_name | unit_name[i];
                wr_data          = wr_data | unit_data_in[i];
            end
        end
    end

    assign unit_write_ready  = gate & {N{wr_write_ready}};
    assign unit_writer_ready = gate & {N{wr_writer_ready}};
    assign unit_write_done   = gate & {N{wr_write_done}};

endmodule

// File: rtl/matrix_op_dispatcher.sv
// Command front-end: launches one op unit at a time, routes shared ports to it while
// it runs, then reports its status and run-cycle count.
module matrix_op_dispatcher
    import matrix_op_defs_pkg::*;
#(
    parameter int NUM_UNITS     = 4,
    parameter int ADDR_WIDTH    = MATRIX_ADDR_WIDTH,
    parameter int DATA_WIDTH    = MATRIX_DATA_WIDTH,
    parameter int START_TIMEOUT = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [OP_SEL_W-1:0]                  cmd_op,
    input  logic [2:0]                           cmd_a_id,
    input  logic [2:0]                           cmd_b_id,
    output logic                                 busy,
    output logic                                 done,
    output matrix_op_status_e                    status,
    output logic [15:0]                          run_cycles,
    output state_t                               fsm_state,
    output logic [NUM_UNITS-1:0]                 unit_start,
    output logic [2:0]                           unit_a_id,
    output logic [2:0]                           unit_b_id,
    input  logic [NUM_UNITS-1:0]                 unit_busy,
    input  logic [NUM_UNITS-1:0][STATUS_W-1:0]   unit_status,
    input  logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0] unit_read_addr,
    output logic [ADDR_WIDTH-1:0]                mem_read_addr,
    input  logic [NUM_UNITS-1:0]                 unit_write_request,
    input  logic [NUM_UNITS-1:0]                 unit_data_valid,
    input  logic [NUM_UNITS-1:0][2:0]            unit_matrix_id,
    input  logic [NUM_UNITS-1:0][7:0]            unit_rows,
    input  logic [NUM_UNITS-1:0][7:0]            unit_cols,
    input  logic [NUM_UNITS-1:0][63:0]           unit_name,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_data_in,
    output logic                                 wr_write_request,
    output logic                                 wr_data_valid,
    output logic [2:0]                           wr_matrix_id,
    output logic [7:0]                           wr_rows,
    output logic [7:0]                           wr_cols,
    output logic [63:0]                          wr_name,
    output logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 wr_write_ready,
    input  logic                                 wr_writer_ready,
    input  logic                                 wr_write_done,
    output logic [NUM_UNITS-1:0]                 unit_write_ready,
    output logic [NUM_UNITS-1:0]                 unit_writer_ready,
    output logic [NUM_UNITS-1:0]                 unit_write_done
);

    localparam int                  TMO_W         = $clog2(START_TIMEOUT + 1);
    localparam logic [OP_SEL_W:0]   NUM_UNITS_LIM = (OP_SEL_W + 1)'(NUM_UNITS);

    state_t                 state;
    logic [OP_SEL_W-1:0]    sel_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [NUM_UNITS-1:0]   cmd_oh;
    logic [NUM_UNITS-1:0]   sel_oh;
    logic                   sel_busy;
    logic                   route_en;
    matrix_op_status_e      sel_status;

    // Handshake: a command is taken on any clock edge where cmd_valid & cmd_ready;
    // cmd_ready is high only in IDLE, so a requester simply holds until then.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    assign route_en  = (state == LAUNCH) || (state == WAIT_BUSY) || (state == RUN);

    always_comb begin
        cmd_oh     = '0;
        sel_oh     = '0;
        sel_status = MATRIX_OP_STATUS_IDLE;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cmd_oh[i] = (cmd_op == OP_SEL_W'(i));
            sel_oh[i] = (sel_q == OP_SEL_W'(i));
            if (sel_q == OP_SEL_W'(i)) sel_status = matrix_op_status_e'(unit_status[i]);
        end
    end

    // Busy from units other than the selected one never reaches the FSM.
    assign sel_busy = |(unit_busy & sel_oh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_q      <= '0;
            unit_a_id  <= '0;
            unit_b_id  <= '0;
            status     <= MATRIX_OP_STATUS_IDLE;
            run_cycles <= '0;
            tmo_q      <= '0;
            unit_start <= '0;
            done       <= 1'b0;
        end else begin
            unit_start <= '0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sel_q      <= cmd_op;
                        unit_a_id  <= cmd_a_id;
                        unit_b_id  <= cmd_b_id;
                        status     <= MATRIX_OP_STATUS_BUSY;
                        run_cycles <= '0;
                        if ({1'b0, cmd_op} >= NUM_UNITS_LIM) begin
                            status <= MATRIX_OP_STATUS_ERR_INTERNAL;
                            done   <= 1'b1;
                            state  <= REPORT;
                        end else begin
                            unit_start <= cmd_oh;
                            state      <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    tmo_q <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (sel_busy) begin
                        state <= RUN;
                    end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
                        status <= MATRIX_OP_STATUS_ERR_INTERNAL;
                        done   <= 1'b1;
                        state  <= REPORT;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                RUN: begin
                    if (run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
                    if (!sel_busy) begin
                        status <= sel_status;
                        done   <= 1'b1;
                        state  <= REPORT;
                    end
                end
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    matrix_op_port_mux #(
        .N  (NUM_UNITS),
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH)
    ) u_port_mux (
        .en                 (route_en),
        .sel                (sel_oh),
        .unit_read_addr     (unit_read_addr),
        .mem_read_addr      (mem_read_addr),
        .unit_write_request (unit_write_request),
        .unit_data_valid    (unit_data_valid),
        .unit_matrix_id     (unit_matrix_id),
        .unit_rows          (unit_rows),
        .unit_cols          (unit_cols),
        .unit_name          (unit_name),
        .unit_data_in       (unit_data_in),
        .wr_write_request   (wr_write_request),
        .wr_data_valid      (wr_data_valid),
        .wr_matrix_id       (wr_matrix_id),
        .wr_rows            (wr_rows),
        .wr_cols            (wr_cols),
        .wr_name            (wr_name),
        .wr_data            (wr_data),
        .wr_write_ready     (wr_write_ready),
        .wr_writer_ready    (wr_writer_ready),
        .wr_write_done      (wr_write_done),
        .unit_write_ready   (unit_write_ready),
        .unit_writer_ready  (unit_writer_ready),
        .unit_write_done    (unit_write_done)
    );

endmodule

// File: tb/tb_matrix_op_dispatcher.sv
// Bench for matrix_op_dispatcher: scripted stub units, randomized commands and writer
// traffic, checked cycle by cycle against a latency/status model of the command flow.
module tb_matrix_op_dispatcher;
    import matrix_op_defs_pkg::*;

    localparam int NU  = 4;
    localparam int AW  = MATRIX_ADDR_WIDTH;
    localparam int DW  = MATRIX_DATA_WIDTH;
    localparam int TMO = 8;
    localparam int WRW = 2 + 3 + 8 + 8 + 64 + DW;

    logic                      clk;
    logic                      rst_n;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [OP_SEL_W-1:0]       cmd_op;
    logic [2:0]                cmd_a_id, cmd_b_id;
    logic                      busy, done;
    matrix_op_status_e         status;
    logic [15:0]               run_cycles;
    state_t                    fsm_state;
    logic [NU-1:0]             unit_start;
    logic [2:0]                unit_a_id, unit_b_id;
    logic [NU-1:0]             unit_busy;
    logic [NU-1:0][STATUS_W-1:0] unit_status;
    logic [NU-1:0][AW-1:0]     unit_read_addr;
    logic [AW-1:0]             mem_read_addr;
    logic [NU-1:0]             unit_write_request, unit_data_valid;
    logic [NU-1:0][2:0]        unit_matrix_id;
    logic [NU-1:0][7:0]        unit_rows, unit_cols;
    logic [NU-1:0][63:0]       unit_name;
    logic [NU-1:0][DW-1:0]     unit_data_in;
    logic                      wr_write_request, wr_data_valid;
    logic [2:0]                wr_matrix_id;
    logic [7:0]                wr_rows, wr_cols;
    logic [63:0]               wr_name;
    logic [DW-1:0]             wr_data;
    logic                      wr_write_ready, wr_writer_ready, wr_write_done;
    logic [NU-1:0]             unit_write_ready, unit_writer_ready, unit_write_done;

    int total = 0;
    int bad   = 0;
    logic [STATUS_W+15:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    matrix_op_dispatcher #(.NUM_UNITS(NU), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a_id(cmd_a_id), .cmd_b_id(cmd_b_id), .busy(busy), .done(done), .status(status),
        .run_cycles(run_cycles), .fsm_state(fsm_state), .unit_start(unit_start),
        .unit_a_id(unit_a_id), .unit_b_id(unit_b_id), .unit_busy(unit_busy),
        .unit_status(unit_status), .unit_read_addr(unit_read_addr), .mem_read_addr(mem_read_addr),
        .unit_write_request(unit_write_request), .unit_data_valid(unit_data_valid),
        .unit_matrix_id(unit_matrix_id), .unit_rows(unit_rows), .unit_cols(unit_cols),
        .unit_name(unit_name), .unit_data_in(unit_data_in), .wr_write_request(wr_write_request),
        .wr_data_valid(wr_data_valid), .wr_matrix_id(wr_matrix_id), .wr_rows(wr_rows),
        .wr_cols(wr_cols), .wr_name(wr_name), .wr_data(wr_data), .wr_write_ready(wr_write_ready),
        .wr_writer_ready(wr_writer_ready), .wr_write_done(wr_write_done),
        .unit_write_ready(unit_write_ready), .unit_writer_ready(unit_writer_ready),
        .unit_write_done(unit_write_done)
    );

    // Stub units: the addressed one raises busy lat cycles after its start pulse and
    // holds it for dur cycles (lat=0 means never); the rest toggle busy at random.
    task automatic drive_units(input int op, input int k, input int lat, input int dur);
        for (int i = 0; i < NU; i++) begin
            if (i == op) unit_busy[i] = (lat >= 1 && k >= lat + 1 && k <= lat + dur);
            else         unit_busy[i] = 1'($urandom_range(0, 1));
            unit_matrix_id[i] = 3'($urandom);
            unit_rows[i]      = 8'($urandom);
            unit_cols[i]      = 8'($urandom);
            unit_name[i]      = {$urandom, $urandom};
            unit_data_in[i]   = DW'($urandom);
        end
        unit_write_request = NU'($urandom);
        unit_data_valid    = NU'($urandom);
        wr_write_ready     = 1'($urandom);
        wr_writer_ready    = 1'($urandom);
        wr_write_done      = 1'($urandom);
    endtask

    task automatic randomize_units();
        for (int i = 0; i < NU; i++) begin
            unit_read_addr[i] = AW'($urandom);
            unit_status[i]    = STATUS_W'($urandom_range(2, 5));
        end
    endtask

    // Caller is at a negedge in an IDLE cycle. Model: out-of-range op reports in the
    // cycle after accept; a unit raising busy within TMO cycles gives done lat+dur+2
    // cycles after accept with run_cycles=dur; otherwise the timeout reports at TMO+2.
    task automatic run_cmd(input int op, input int a, input int b, input int lat,
                           input int dur, input bit hold, input int hop);
        bit in_range, act;
        int done_k, opi;
        matrix_op_status_e fin_st, exp_st;
        logic [15:0] fin_run;
        logic [STATUS_W+15:0] exp_sb;
        logic [NU-1:0] exp_start, exp_wrdy, exp_wrrdy, exp_wdone;
        logic [WRW-1:0] exp_wr, got_wr;
        logic [AW-1:0] exp_addr;
        in_range = (op < NU);
        opi = in_range ? op : 0;
        if (!in_range) begin
            done_k = 1; fin_st = MATRIX_OP_STATUS_ERR_INTERNAL; fin_run = 16'd0;
        end else if (lat >= 1 && lat <= TMO) begin
            done_k = lat + dur + 2; fin_st = matrix_op_status_e'(unit_status[opi]); fin_run = 16'(dur);
        end else begin
            done_k = TMO + 2; fin_st = MATRIX_OP_STATUS_ERR_INTERNAL; fin_run = 16'd0;
        end
        exp_q.push_back({fin_st, fin_run});
        cmd_valid = 1'b1; cmd_op = OP_SEL_W'(op); cmd_a_id = 3'(a); cmd_b_id = 3'(b);
        drive_units(op, 0, lat, dur);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL accept_ready op=%0d got=%b exp=1", op, cmd_ready); end
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge clk);
            act       = in_range && (k < done_k);
            exp_start = (k == 1 && in_range) ? NU'(1 << op) : '0;
            exp_st    = (k < done_k) ? MATRIX_OP_STATUS_BUSY : fin_st;
            exp_addr  = act ? unit_read_addr[opi] : '0;
            exp_wr    = act ? {unit_write_request[opi], unit_data_valid[opi], unit_matrix_id[opi],
                               unit_rows[opi], unit_cols[opi], unit_name[opi], unit_data_in[opi]} : '0;
            got_wr    = {wr_write_request, wr_data_valid, wr_matrix_id, wr_rows, wr_cols, wr_name, wr_data};
            exp_wrdy = '0; exp_wrrdy = '0; exp_wdone = '0;
            if (act) begin
                exp_wrdy[opi] = wr_write_ready; exp_wrrdy[opi] = wr_writer_ready; exp_wdone[opi] = wr_write_done;
            end
            total++;
            if (unit_start !== exp_start) begin bad++; $display("FAIL unit_start op=%0d k=%0d got=%b exp=%b", op, k, unit_start, exp_start); end
            total++;
            if (done !== (k == done_k)) begin bad++; $display("FAIL done op=%0d k=%0d got=%b exp=%b", op, k, done, k == done_k); end
            total++;
            if ({busy, cmd_ready} !== {k <= done_k, k > done_k}) begin
                bad++; $display("FAIL busy_ready op=%0d k=%0d got=%b%b done_k=%0d", op, k, busy, cmd_ready, done_k);
            end
            total++;
            if (status !== exp_st) begin bad++; $display("FAIL status op=%0d k=%0d got=%0d exp=%0d", op, k, status, exp_st); end
            total++;
            if (mem_read_addr !== exp_addr) begin bad++; $display("FAIL mem_addr op=%0d k=%0d got=%h exp=%h", op, k, mem_read_addr, exp_addr); end
            total++;
            if (got_wr !== exp_wr) begin bad++; $display("FAIL wr_mux op=%0d k=%0d got=%h exp=%h", op, k, got_wr, exp_wr); end
            total++;
            if ({unit_write_ready, unit_writer_ready, unit_write_done} !== {exp_wrdy, exp_wrrdy, exp_wdone}) begin
                bad++; $display("FAIL ready_demux op=%0d k=%0d got=%b exp=%b", op, k,
                                {unit_write_ready, unit_writer_ready, unit_write_done}, {exp_wrdy, exp_wrrdy, exp_wdone});
            end
            if (k == done_k) begin
                exp_sb = exp_q.pop_front();
                total++;
                if ({status, run_cycles} !== exp_sb) begin
                    bad++; $display("FAIL result op=%0d got=%0d/%0d exp=%0d/%0d", op, status, run_cycles, exp_sb[18:16], exp_sb[15:0]);
                end
                total++;
                if ({unit_a_id, unit_b_id} !== {3'(a), 3'(b)}) begin
                    bad++; $display("FAIL ids op=%0d got=%0d,%0d exp=%0d,%0d", op, unit_a_id, unit_b_id, a, b);
                end
            end
            if (k == 1) cmd_valid = 1'b0;
            if (hold && k >= 2) begin cmd_valid = 1'b1; cmd_op = OP_SEL_W'(hop); end
            drive_units(op, k, lat, dur);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a_id = '0; cmd_b_id = '0;
        randomize_units();
        drive_units(-1, 0, 0, 0);
        unit_data_valid = '1; unit_write_request = '1; wr_writer_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({cmd_ready, busy, done, unit_start} !== {1'b1, 1'b0, 1'b0, {NU{1'b0}}}) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=100%b", {cmd_ready, busy, done, unit_start}, {NU{1'b0}});
        end
        total++;
        if ({status, run_cycles, unit_a_id, unit_b_id} !== {MATRIX_OP_STATUS_IDLE, 16'd0, 6'd0}) begin
            bad++; $display("FAIL reset_regs got=%0d/%0d/%0d/%0d exp=0/0/0/0", status, run_cycles, unit_a_id, unit_b_id);
        end
        total++;
        if ({mem_read_addr, wr_write_request, wr_data_valid, unit_writer_ready} !== '0) begin
            bad++; $display("FAIL reset_route got=%h/%b/%b/%b exp=0", mem_read_addr, wr_write_request, wr_data_valid, unit_writer_ready);
        end
        total++;
        if (fsm_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, IDLE); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_basic();
        randomize_units();
        unit_status[0] = STATUS_W'(MATRIX_OP_STATUS_SUCCESS);
        run_cmd(int'(OP_ADD), 1, 2, 1, 10, 1'b0, 0);
    endtask

    task automatic test_routing();
        randomize_units();
        for (int i = 0; i < NU; i++) unit_read_addr[i] = AW'(12'h0AA);
        unit_read_addr[3] = AW'(12'h123);
        run_cmd(int'(OP_TRANSPOSE), 4, 5, 2, 6, 1'b0, 0);
    endtask

    task automatic test_out_of_range();
        for (int op = NU; op < NUM_UNITS_MAX; op++) begin
            randomize_units();
            run_cmd(op, op - NU, 7, 1, 3, 1'b0, 0);
        end
    endtask

    task automatic test_timeout();
        randomize_units();
        run_cmd(int'(OP_MUL), 3, 3, 0, 1, 1'b0, 0);
        randomize_units();
        run_cmd(int'(OP_SCALAR), 2, 6, TMO + 1, 4, 1'b0, 0);
        randomize_units();
        run_cmd(int'(OP_SCALAR), 6, 2, TMO, 2, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        randomize_units();
        run_cmd(1, 2, 5, 1, 12, 1'b1, 2);
        run_cmd(2, 2, 5, 3, 4, 1'b0, 0);
    endtask

    task automatic test_reset_mid_run();
        randomize_units();
        cmd_valid = 1'b1; cmd_op = OP_SEL_W'(1); cmd_a_id = 3'd5; cmd_b_id = 3'd6;
        drive_units(1, 0, 1, 30);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            drive_units(1, k, 1, 30);
        end
        unit_data_valid = '1;
        #1;
        total++;
        if ({busy, wr_data_valid} !== 2'b11) begin bad++; $display("FAIL pre_reset_run got=%b%b exp=11", busy, wr_data_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, wr_data_valid, cmd_ready, unit_start} !== {3'b001, {NU{1'b0}}}) begin
            bad++; $display("FAIL mid_reset_ctrl got=%b%b%b%b exp=001%b", busy, wr_data_valid, cmd_ready, unit_start, {NU{1'b0}});
        end
        total++;
        if ({status, run_cycles} !== {MATRIX_OP_STATUS_IDLE, 16'd0}) begin
            bad++; $display("FAIL mid_reset_status got=%0d/%0d exp=0/0", status, run_cycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            unit_busy = NU'(4'b0010);
            total++;
            if ({busy, done, status} !== {2'b00, MATRIX_OP_STATUS_IDLE}) begin
                bad++; $display("FAIL stale_busy k=%0d got=%b%b/%0d exp=00/0", k, busy, done, status);
            end
        end
        unit_busy = '0;
        run_cmd(2, 3, 4, 2, 5, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            randomize_units();
            run_cmd($urandom_range(0, NUM_UNITS_MAX - 1), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, TMO + 2), $urandom_range(1, 12), 1'b0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_routing();
        test_out_of_range();
        test_timeout();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
